// File: rtl/branch_predict_fetch.sv
// ----------------------------------------------------------------------------
// branch_predict_fetch
//
// Fetch-stage branch predictor with a bimodal history table. It decodes the
// fetched word, predicts conditional branches with 2-bit counters, selects
// the next PC and loads the IF/ID register. A small shift queue tracks
// in-flight branches until they are resolved. A wrong guess produces a
// combinational flush request and the alternate PC.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   pc_in           address of the instruction being fetched
//   instr_in        fetched instruction word
//   if_id_write     1 = pipeline advances, 0 = stall (queue and IF/ID hold)
//   resolve_valid   the oldest in-flight branch resolves this cycle
//   resolve_taken   actual outcome of that branch
//   next_pc         address for the external PC register
//   instr_out, pc_plus4_out, pred_taken_out   IF/ID register
//   mispredict      combinational flush request
//   mispredict_cnt  saturating count of mispredicted resolutions
//
// Parameter limits: BHT_ENTRIES must be a power of two and at least 2.
// ADDR_W must be at least 29, because the jump target keeps pc4[ADDR_W-1:28].
// ----------------------------------------------------------------------------
module branch_predict_fetch #(
    parameter int ADDR_W        = 32,
    parameter int BHT_ENTRIES   = 16,
    parameter int RESOLVE_DEPTH = 3,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [31:0]       instr_in,
    input  logic              if_id_write,
    input  logic              resolve_valid,
    input  logic              resolve_taken,
    output logic [ADDR_W-1:0] next_pc,
    output logic [31:0]       instr_out,
    output logic [ADDR_W-1:0] pc_plus4_out,
    output logic              pred_taken_out,
    output logic              mispredict,
    output logic [CNT_W-1:0]  mispredict_cnt
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam int HEAD  = RESOLVE_DEPTH - 1;   // oldest queue slot

    // Fetch-side decode and targets
    logic              is_branch, is_jump, pred;
    logic [IDX_W-1:0]  fetch_idx;
    logic [ADDR_W-1:0] pc4, br_off, br_tgt, jmp_tgt;

    // Predictor table
    logic [1:0] bht_q [BHT_ENTRIES];
    logic [1:0] bht_d [BHT_ENTRIES];

    // In-flight queue. Slot 0 is the newest entry and slot HEAD is the oldest.
    logic [RESOLVE_DEPTH-1:0] qv_q, qv_d, qp_q, qp_d;
    logic [ADDR_W-1:0]        qa_q [RESOLVE_DEPTH];
    logic [ADDR_W-1:0]        qa_d [RESOLVE_DEPTH];
    logic [IDX_W-1:0]         qi_q [RESOLVE_DEPTH];
    logic [IDX_W-1:0]         qi_d [RESOLVE_DEPTH];

    // IF/ID register and statistics
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] pc4_q, pc4_d;
    logic              pred_q, pred_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic resolve_hit;

    assign is_branch = (instr_in[31:26] == 6'b000100);
    assign is_jump   = (instr_in[31:26] == 6'b000010);
    assign fetch_idx = pc_in[IDX_W+1:2];
    assign pred      = is_branch & bht_q[fetch_idx][1];

    assign pc4     = pc_in + ADDR_W'(4);
    assign br_off  = {{(ADDR_W-18){instr_in[15]}}, instr_in[15:0], 2'b00};
    assign br_tgt  = pc4 + br_off;
    assign jmp_tgt = {pc4[ADDR_W-1:28], instr_in[25:0], 2'b00};

    // A resolution counts only when an in-flight branch actually sits at the head.
    assign resolve_hit = resolve_valid & qv_q[HEAD];
    assign mispredict  = resolve_hit & (resolve_taken != qp_q[HEAD]);

    always_comb begin
        next_pc = pc4;
        if (mispredict)   next_pc = qa_q[HEAD];
        else if (is_jump) next_pc = jmp_tgt;
        else if (pred)    next_pc = br_tgt;
    end

    genvar gi;
    generate
        for (gi = 0; gi < RESOLVE_DEPTH; gi++) begin : g_queue
            // A flush clears every valid bit. This wins over both a shift and a hold.
            if (gi == 0) begin : g_tail
                // Nothing fetched in the flush cycle is on the correct path.
                assign qv_d[gi] = mispredict ? 1'b0
                                : (if_id_write ? (is_branch & ~mispredict) : qv_q[gi]);
                assign qp_d[gi] = if_id_write ? pred : qp_q[gi];
                // Keep the PC that was not chosen, so a flush can redirect to it.
                assign qa_d[gi] = if_id_write ? (pred ? pc4 : br_tgt) : qa_q[gi];
                assign qi_d[gi] = if_id_write ? fetch_idx : qi_q[gi];
            end else begin : g_body
                assign qv_d[gi] = mispredict ? 1'b0
                                : (if_id_write ? qv_q[gi-1] : qv_q[gi]);
                assign qp_d[gi] = if_id_write ? qp_q[gi-1] : qp_q[gi];
                assign qa_d[gi] = if_id_write ? qa_q[gi-1] : qa_q[gi];
                assign qi_d[gi] = if_id_write ? qi_q[gi-1] : qi_q[gi];
            end
        end

        // Saturating counter update. The fetch lookup reads bht_q, so a lookup
        // of the same index in the same cycle still sees the old value.
        for (gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
            logic [1:0] sat_val;
            assign sat_val = resolve_taken
                           ? ((bht_q[gi] == 2'b11) ? 2'b11 : bht_q[gi] + 2'b01)
                           : ((bht_q[gi] == 2'b00) ? 2'b00 : bht_q[gi] - 2'b01);
            assign bht_d[gi] = (resolve_hit && (qi_q[HEAD] == IDX_W'(gi)))
                             ? sat_val : bht_q[gi];
        end
    endgenerate

    // On a flush, the IF/ID register takes a bubble. pc_plus4 is left
    // unchanged because nothing downstream uses it for a bubble.
    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        pred_d  = pred_q;
        if (mispredict) begin
            instr_d = '0;
            pred_d  = 1'b0;
        end else if (if_id_write) begin
            instr_d = instr_in;
            pc4_d   = pc4;
            pred_d  = pred;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (mispredict && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= '0;
            pc4_q   <= '0;
            pred_q  <= 1'b0;
            cnt_q   <= '0;
            qv_q    <= '0;
            qp_q    <= '0;
            for (int i = 0; i < RESOLVE_DEPTH; i++) begin
                qa_q[i] <= '0;
                qi_q[i] <= '0;
            end
            for (int i = 0; i < BHT_ENTRIES; i++)
                bht_q[i] <= 2'b01;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            pred_q  <= pred_d;
            cnt_q   <= cnt_d;
            qv_q    <= qv_d;
            qp_q    <= qp_d;
            for (int i = 0; i < RESOLVE_DEPTH; i++) begin
                qa_q[i] <= qa_d[i];
                qi_q[i] <= qi_d[i];
            end
            for (int i = 0; i < BHT_ENTRIES; i++)
                bht_q[i] <= bht_d[i];
        end
    end

    assign instr_out      = instr_q;
    assign pc_plus4_out   = pc4_q;
    assign pred_taken_out = pred_q;
    assign mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_branch_predict_fetch.sv
// ----------------------------------------------------------------------------
// tb_branch_predict_fetch
//
// Directed testbench for branch_predict_fetch with default parameters
// (ADDR_W=32, BHT_ENTRIES=16, RESOLVE_DEPTH=3, CNT_W=16). Inputs change 1 ns
// after a rising edge. Combinational outputs are sampled 1 ns after that, and
// registered outputs 1 ns after the following edge.
// ----------------------------------------------------------------------------
module tb_branch_predict_fetch;

    localparam logic [31:0] BEQ = 32'h1000_0003;   // beq, imm 3 -> target pc4+12
    localparam logic [31:0] JMP = 32'h0800_0010;   // j 0x10 -> target 0x40
    localparam logic [31:0] ALU = 32'h2000_0000;   // non-branch, non-jump

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_in = '0;
    logic [31:0] instr_in = '0;
    logic        if_id_write = 1'b0;
    logic        resolve_valid = 1'b0;
    logic        resolve_taken = 1'b0;
    logic [31:0] next_pc;
    logic [31:0] instr_out;
    logic [31:0] pc_plus4_out;
    logic        pred_taken_out;
    logic        mispredict;
    logic [15:0] mispredict_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    branch_predict_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_in),
        .instr_in       (instr_in),
        .if_id_write    (if_id_write),
        .resolve_valid  (resolve_valid),
        .resolve_taken  (resolve_taken),
        .next_pc        (next_pc),
        .instr_out      (instr_out),
        .pc_plus4_out   (pc_plus4_out),
        .pred_taken_out (pred_taken_out),
        .mispredict     (mispredict),
        .mispredict_cnt (mispredict_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_nop();
        pc_in = 32'h200; instr_in = 32'h0; if_id_write = 1'b1;
        resolve_valid = 1'b0; resolve_taken = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_nop();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Fetch the beq at 0x40, advance two bubbles so that it reaches the head,
    // then resolve it. Returns the next_pc seen at fetch, and the mispredict
    // and next_pc seen in the resolve cycle.
    task automatic run_branch(input logic taken, output logic [31:0] pred_np,
                              output logic mp, output logic [31:0] res_np);
        pc_in = 32'h40; instr_in = BEQ; if_id_write = 1'b1; resolve_valid = 1'b0;
        #1 pred_np = next_pc;
        cyc();
        drive_nop();
        cyc();
        cyc();
        resolve_valid = 1'b1; resolve_taken = taken;
        #1 mp = mispredict; res_np = next_pc;
        cyc();
        resolve_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        pc_in = 32'h40; instr_in = BEQ; if_id_write = 1'b1;
        resolve_valid = 1'b1; resolve_taken = 1'b1;
        #3;
        n_checks++;
        if (instr_out !== 32'h0) begin n_fail++; $display("FAIL reset_instr_out: got %h want 0", instr_out); end
        n_checks++;
        if (pc_plus4_out !== 32'h0) begin n_fail++; $display("FAIL reset_pc_plus4: got %h want 0", pc_plus4_out); end
        n_checks++;
        if (pred_taken_out !== 1'b0) begin n_fail++; $display("FAIL reset_pred: got %b want 0", pred_taken_out); end
        n_checks++;
        if (mispredict_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0", mispredict_cnt); end
        n_checks++;
        if (mispredict !== 1'b0) begin n_fail++; $display("FAIL reset_mispredict: got %b want 0", mispredict); end
        $display("test_reset: done");
    endtask

    task automatic test_not_taken_fetch();
        do_reset();
        pc_in = 32'h40; instr_in = BEQ; if_id_write = 1'b1;
        #1;
        n_checks++;
        if (next_pc !== 32'h44) begin n_fail++; $display("FAIL cold_next_pc: got %h want 44", next_pc); end
        cyc();
        n_checks++;
        if (instr_out !== BEQ) begin n_fail++; $display("FAIL cold_instr_out: got %h want %h", instr_out, BEQ); end
        n_checks++;
        if (pc_plus4_out !== 32'h44) begin n_fail++; $display("FAIL cold_pc_plus4: got %h want 44", pc_plus4_out); end
        n_checks++;
        if (pred_taken_out !== 1'b0) begin n_fail++; $display("FAIL cold_pred: got %b want 0", pred_taken_out); end
        $display("test_not_taken_fetch: done");
    endtask

    task automatic test_train_taken();
        logic [31:0] pnp, rnp;
        logic        mp;
        do_reset();
        run_branch(1'b1, pnp, mp, rnp);
        n_checks++;
        if (mp !== 1'b1) begin n_fail++; $display("FAIL train1_mispredict: got %b want 1", mp); end
        n_checks++;
        if (rnp !== 32'h50) begin n_fail++; $display("FAIL train1_redirect: got %h want 50", rnp); end
        n_checks++;
        if (mispredict_cnt !== 16'd1) begin n_fail++; $display("FAIL train1_cnt: got %0d want 1", mispredict_cnt); end
        n_checks++;
        if (instr_out !== 32'h0) begin n_fail++; $display("FAIL train1_flush_instr: got %h want 0", instr_out); end
        run_branch(1'b1, pnp, mp, rnp);
        n_checks++;
        if (pnp !== 32'h50) begin n_fail++; $display("FAIL train2_pred_np: got %h want 50", pnp); end
        n_checks++;
        if (mp !== 1'b0) begin n_fail++; $display("FAIL train2_mispredict: got %b want 0", mp); end
        n_checks++;
        if (mispredict_cnt !== 16'd1) begin n_fail++; $display("FAIL train2_cnt: got %0d want 1", mispredict_cnt); end
        pc_in = 32'h40; instr_in = BEQ; if_id_write = 1'b1;
        #1;
        n_checks++;
        if (next_pc !== 32'h50) begin n_fail++; $display("FAIL train3_next_pc: got %h want 50", next_pc); end
        cyc();
        n_checks++;
        if (pred_taken_out !== 1'b1) begin n_fail++; $display("FAIL train3_pred_out: got %b want 1", pred_taken_out); end
        $display("test_train_taken: done");
    endtask

    task automatic test_mispredict_stall();
        logic [31:0] pnp, rnp;
        logic        mp;
        do_reset();
        run_branch(1'b1, pnp, mp, rnp);       // counter 01 -> 10
        // The IF/ID register now holds a bubble, so pc_plus4 is still 0x204 from the nops.
        pc_in = 32'h40; instr_in = BEQ; if_id_write = 1'b1;
        cyc(); cyc(); cyc();                    // three predicted-taken beqs queued
        n_checks++;
        if (pc_plus4_out !== 32'h44) begin n_fail++; $display("FAIL stall_pre_pc4: got %h want 44", pc_plus4_out); end
        pc_in = 32'h300; instr_in = ALU; if_id_write = 1'b0;
        resolve_valid = 1'b1; resolve_taken = 1'b0;
        #1;
        n_checks++;
        if (mispredict !== 1'b1) begin n_fail++; $display("FAIL stall_mispredict: got %b want 1", mispredict); end
        n_checks++;
        if (next_pc !== 32'h44) begin n_fail++; $display("FAIL stall_redirect: got %h want 44", next_pc); end
        cyc();
        n_checks++;
        if (instr_out !== 32'h0) begin n_fail++; $display("FAIL stall_flush_instr: got %h want 0", instr_out); end
        n_checks++;
        if (pred_taken_out !== 1'b0) begin n_fail++; $display("FAIL stall_flush_pred: got %b want 0", pred_taken_out); end
        n_checks++;
        if (pc_plus4_out !== 32'h44) begin n_fail++; $display("FAIL stall_pc4_held: got %h want 44", pc_plus4_out); end
        n_checks++;
        if (mispredict_cnt !== 16'd2) begin n_fail++; $display("FAIL stall_cnt: got %0d want 2", mispredict_cnt); end
        // Every entry must now be invalid. A not-taken resolve against any of
        // the old predicted-taken entries would raise mispredict.
        if_id_write = 1'b1; pc_in = 32'h200; instr_in = 32'h0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (mispredict !== 1'b0) begin n_fail++; $display("FAIL stall_queue_cleared[%0d]: got %b want 0", k, mispredict); end
            cyc();
        end
        resolve_valid = 1'b0;
        $display("test_mispredict_stall: done");
    endtask

    task automatic test_jump();
        do_reset();
        pc_in = 32'h1000; instr_in = JMP; if_id_write = 1'b1;
        #1;
        n_checks++;
        if (next_pc !== 32'h40) begin n_fail++; $display("FAIL jump_next_pc: got %h want 40", next_pc); end
        cyc();
        n_checks++;
        if (instr_out !== JMP) begin n_fail++; $display("FAIL jump_instr_out: got %h want %h", instr_out, JMP); end
        drive_nop();
        cyc(); cyc();                            // the jump would now be at the head
        resolve_valid = 1'b1; resolve_taken = 1'b1;
        #1;
        n_checks++;
        if (mispredict !== 1'b0) begin n_fail++; $display("FAIL jump_not_queued: got %b want 0", mispredict); end
        cyc();
        resolve_valid = 1'b0;
        n_checks++;
        if (mispredict_cnt !== 16'd0) begin n_fail++; $display("FAIL jump_cnt: got %0d want 0", mispredict_cnt); end
        $display("test_jump: done");
    endtask

    task automatic test_saturation();
        logic [31:0] pnp, rnp;
        logic        mp;
        // Upper bound: 01 -> 10 -> 11 -> 11. A wrap to 00 would predict not-taken.
        do_reset();
        run_branch(1'b1, pnp, mp, rnp);
        run_branch(1'b1, pnp, mp, rnp);
        run_branch(1'b1, pnp, mp, rnp);
        n_checks++;
        if (mp !== 1'b0) begin n_fail++; $display("FAIL sat_hi_mispredict: got %b want 0", mp); end
        pc_in = 32'h40; instr_in = BEQ; if_id_write = 1'b1;
        #1;
        n_checks++;
        if (next_pc !== 32'h50) begin n_fail++; $display("FAIL sat_hi_next_pc: got %h want 50", next_pc); end
        // Lower bound: 01 -> 00 -> 00 -> (taken) 01. A wrap would reach 11 and predict taken.
        do_reset();
        run_branch(1'b0, pnp, mp, rnp);
        run_branch(1'b0, pnp, mp, rnp);
        n_checks++;
        if (mp !== 1'b0) begin n_fail++; $display("FAIL sat_lo_mispredict: got %b want 0", mp); end
        run_branch(1'b1, pnp, mp, rnp);
        n_checks++;
        if (pnp !== 32'h44) begin n_fail++; $display("FAIL sat_lo_pred_np: got %h want 44", pnp); end
        pc_in = 32'h40; instr_in = BEQ; if_id_write = 1'b1;
        #1;
        n_checks++;
        if (next_pc !== 32'h44) begin n_fail++; $display("FAIL sat_lo_next_pc: got %h want 44", next_pc); end
        // Resolving with an empty queue changes nothing.
        do_reset();
        resolve_valid = 1'b1; resolve_taken = 1'b1;
        #1;
        n_checks++;
        if (mispredict !== 1'b0) begin n_fail++; $display("FAIL empty_mispredict: got %b want 0", mispredict); end
        cyc();
        resolve_valid = 1'b0;
        n_checks++;
        if (mispredict_cnt !== 16'd0) begin n_fail++; $display("FAIL empty_cnt: got %0d want 0", mispredict_cnt); end
        pc_in = 32'h40; instr_in = BEQ;
        #1;
        n_checks++;
        if (next_pc !== 32'h44) begin n_fail++; $display("FAIL empty_bht_unchanged: got %h want 44", next_pc); end
        $display("test_saturation: done");
    endtask

    task automatic test_async_reset();
        logic [31:0] pnp, rnp;
        logic        mp;
        do_reset();
        run_branch(1'b1, pnp, mp, rnp);          // leaves the mispredict count at 1
        pc_in = 32'h40; instr_in = BEQ; if_id_write = 1'b1;
        cyc();                                   // beq at slot 0
        pc_in = 32'h300; instr_in = ALU;
        cyc();                                   // beq at slot 1, IF/ID holds ALU
        n_checks++;
        if (instr_out !== ALU) begin n_fail++; $display("FAIL arst_pre_instr: got %h want %h", instr_out, ALU); end
        #2 rst = 1'b1;                           // mid-cycle, no clock edge
        #1;
        n_checks++;
        if (instr_out !== 32'h0) begin n_fail++; $display("FAIL arst_instr: got %h want 0", instr_out); end
        n_checks++;
        if (pc_plus4_out !== 32'h0) begin n_fail++; $display("FAIL arst_pc4: got %h want 0", pc_plus4_out); end
        n_checks++;
        if (mispredict_cnt !== 16'd0) begin n_fail++; $display("FAIL arst_cnt: got %0d want 0", mispredict_cnt); end
        #1 rst = 1'b0;
        drive_nop();
        cyc();                                   // the discarded beq would be at the head now
        resolve_valid = 1'b1; resolve_taken = 1'b1;
        #1;
        n_checks++;
        if (mispredict !== 1'b0) begin n_fail++; $display("FAIL arst_resolve_ignored: got %b want 0", mispredict); end
        cyc();
        resolve_valid = 1'b0;
        $display("test_async_reset: done");
    endtask

    initial begin
        test_reset();
        test_not_taken_fetch();
        test_train_taken();
        test_mispredict_stall();
        test_jump();
        test_saturation();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
